// File: rtl/wb_interconnect.sv
// Single-master Wishbone B4 pipelined interconnect.
// Decodes the top IDX_W address bits into a slave index and routes stb/stall
// to that slave and ack/err/read data back. It keeps responses in order by
// holding one owner slave while any request to it is outstanding. Unmapped
// addresses get a one-cycle bus error, and a silent owner is aborted after
// TIMEOUT idle cycles.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no outstanding requests, decode any new request directly
// ACTIVE   | owner slave selected, requests/responses flowing to/from it
// ERR_RESP | unmapped request accepted, return m_err for one cycle
// ABORT    | owner timed out, drop its cycle and return m_err for one cycle
module wb_interconnect #(
    parameter int NUM_SLAVES      = 4,
    parameter int IDX_W           = 3,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int SEL_W           = DATA_W / 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT         = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         m_cyc,
    input  logic                         m_stb,
    input  logic                         m_we,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W-1:0]            m_data_w,
    input  logic [SEL_W-1:0]             m_sel,
    output logic                         m_stall,
    output logic                         m_ack,
    output logic                         m_err,
    output logic [DATA_W-1:0]            m_data_r,
    output logic [NUM_SLAVES-1:0]        s_cyc,
    output logic [NUM_SLAVES-1:0]        s_stb,
    output logic                         s_we,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_data_w,
    output logic [SEL_W-1:0]             s_sel,
    input  logic [NUM_SLAVES-1:0]        s_stall,
    input  logic [NUM_SLAVES-1:0]        s_ack,
    input  logic [NUM_SLAVES-1:0]        s_err,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_data_r
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        ERR_RESP = 2'd2,
        ABORT    = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    owner, owner_nxt;
    logic [OUT_W-1:0]    outstanding, outstanding_nxt;
    logic [TMR_W-1:0]    timer, timer_nxt;

    logic [IDX_W-1:0]      idx;
    logic [NUM_SLAVES-1:0] idx_oh;
    logic [NUM_SLAVES-1:0] owner_oh;
    logic [DATA_W-1:0]     owner_data;
    logic                  mapped;
    logic                  busy;
    logic                  full;
    logic                  own_resp;
    logic                  accept;
    logic                  dec_req;
    logic [NUM_SLAVES-1:0] cyc_c;
    logic [NUM_SLAVES-1:0] stb_c;
    logic                  stall_c;
    logic                  ack_c;
    logic                  err_c;

    assign idx      = m_addr[ADDR_W-1 -: IDX_W];
    assign mapped   = |idx_oh;
    assign busy     = (outstanding != '0);
    assign full     = (outstanding == OUT_W'(MAX_OUTSTANDING));
    // Only responses from the owner count, and only while something is pending.
    assign own_resp = busy & (|((s_ack | s_err) & owner_oh));

    // One-hot selects for the decoded index and the current owner; an index
    // beyond NUM_SLAVES yields an all-zero vector, which marks it unmapped.
    always_comb begin
        idx_oh   = '0;
        owner_oh = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            idx_oh[i]   = (idx == IDX_W'(i));
            owner_oh[i] = (owner == IDX_W'(i));
        end
    end

    // Read-data mux from the owner slave.
    always_comb begin
        owner_data = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (owner_oh[i]) owner_data = s_data_r[i*DATA_W +: DATA_W];
        end
    end

    // Next-state, counters and routing of strobes/stall/responses.
    always_comb begin
        state_nxt       = state;
        owner_nxt       = owner;
        outstanding_nxt = outstanding;
        timer_nxt       = timer;
        cyc_c           = '0;
        stb_c           = '0;
        stall_c         = 1'b0;
        ack_c           = 1'b0;
        err_c           = 1'b0;
        accept          = 1'b0;
        dec_req         = 1'b0;

        case (state)
            IDLE: begin
                dec_req = m_cyc & m_stb;
            end
            ACTIVE: begin
                if (m_cyc) begin
                    cyc_c = owner_oh;
                    ack_c = busy & (|(s_ack & owner_oh));
                    err_c = busy & (|(s_err & owner_oh));
                    if (m_stb && (idx == owner)) begin
                        stb_c   = owner_oh;
                        stall_c = (|(s_stall & owner_oh)) | full;
                        accept  = ~stall_c;
                    end else if (m_stb && !busy) begin
                        // Owner fully drained: hand the bus to the new target now.
                        dec_req = 1'b1;
                    end else if (m_stb) begin
                        stall_c = 1'b1;
                    end
                end
            end
            ERR_RESP, ABORT: begin
                stall_c = 1'b1;
                err_c   = m_cyc;
            end
            default: ;
        endcase

        if (dec_req) begin
            if (mapped) begin
                cyc_c     = idx_oh;
                stb_c     = idx_oh;
                stall_c   = |(s_stall & idx_oh);
                accept    = ~stall_c;
                owner_nxt = idx;
            end else begin
                cyc_c   = '0;
                stall_c = 1'b0;
            end
        end

        if (!m_cyc || (state == ERR_RESP) || (state == ABORT)) begin
            state_nxt       = IDLE;
            outstanding_nxt = '0;
            timer_nxt       = '0;
        end else if (dec_req && !mapped) begin
            state_nxt = ERR_RESP;
        end else begin
            outstanding_nxt = outstanding + OUT_W'(accept) - OUT_W'(own_resp);
            if (accept || own_resp || !busy) timer_nxt = '0;
            else                             timer_nxt = timer + 1'b1;

            if (busy && !accept && !own_resp && (timer == TMR_W'(TIMEOUT - 1))) begin
                state_nxt       = ABORT;
                outstanding_nxt = '0;
                timer_nxt       = TMR_W'(TIMEOUT);
            end else if ((outstanding_nxt != '0) || (dec_req && mapped)) begin
                state_nxt = ACTIVE;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    // State, owner, outstanding count and timeout timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= '0;
            outstanding <= '0;
            timer       <= '0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            outstanding <= outstanding_nxt;
            timer       <= timer_nxt;
        end
    end

    // Slave-side strobes are forced low and the master is stalled while in reset.
    assign s_cyc    = cyc_c & {NUM_SLAVES{rst_n}};
    assign s_stb    = stb_c & {NUM_SLAVES{rst_n}};
    assign m_stall  = stall_c | ~rst_n;
    assign m_ack    = ack_c;
    assign m_err    = err_c;
    assign m_data_r = (state == ACTIVE) ? owner_data : '0;

    assign s_we     = m_we;
    assign s_addr   = m_addr;
    assign s_data_w = m_data_w;
    assign s_sel    = m_sel;

endmodule

// File: doc/wb_interconnect.md
Name: wb_interconnect

Overview:
Single-master, NUM_SLAVES-slave Wishbone B4 pipelined interconnect between the CPU/boot master and RAM, I2C EEPROM and peripheral slaves. It decodes the upper address bits into a slave index and routes stb/stall/ack/err/read data. It tracks outstanding transactions so acks stay in order, returns a bus error for unmapped addresses, and aborts hung slaves with a timeout. It replaces the ad-hoc case decode at top level.

Parameters:
NUM_SLAVES, 4, number of slave channels (1..2**IDX_W)
IDX_W, 3, address MSBs used as slave index
ADDR_W, 32, master address width
DATA_W, 32, data bus width
SEL_W, DATA_W/8, byte-select width
MAX_OUTSTANDING, 4, max accepted-but-unacknowledged requests (>=1)
TIMEOUT, 255, cycles without ack/err (while outstanding>0) before abort (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
m_cyc  in  1  master cycle
m_stb  in  1  master strobe
m_we  in  1  master write enable
m_addr  in  ADDR_W  master address
m_data_w  in  DATA_W  master write data
m_sel  in  SEL_W  master byte select
m_stall  out  1  stall to master
m_ack  out  1  ack to master
m_err  out  1  error to master
m_data_r  out  DATA_W  read data to master
s_cyc  out  NUM_SLAVES  per-slave cycle
s_stb  out  NUM_SLAVES  per-slave strobe
s_we  out  1  shared write enable
s_addr  out  ADDR_W  shared address (full m_addr)
s_data_w  out  DATA_W  shared write data
s_sel  out  SEL_W  shared byte select
s_stall  in  NUM_SLAVES  per-slave stall
s_ack  in  NUM_SLAVES  per-slave ack
s_err  in  NUM_SLAVES  per-slave error
s_data_r  in  NUM_SLAVES*DATA_W  per-slave read data, slave i at [i*DATA_W +: DATA_W]

Behaviour:
- Reset (async, rst_n=0): state IDLE, owner=0, outstanding=0, timer=0; s_cyc=0, s_stb=0, m_ack=0, m_err=0, m_data_r=0. m_stall=1 while in reset.
- Decode: idx = m_addr[ADDR_W-1 -: IDX_W]. Mapped iff idx < NUM_SLAVES.
- s_we/s_addr/s_data_w/s_sel: combinational pass-through from master.
- States: IDLE, ACTIVE(owner), ERR_RESP, ABORT.
- IDLE: m_stall=0. m_cyc&m_stb with mapped idx: owner<=idx, go ACTIVE, s_cyc[owner] asserted combinationally that cycle, s_stb[idx]=m_stb, m_stall=s_stall[idx]. Acceptance is stb&~stall (count increments). Unmapped: accept (m_stall=0), go ERR_RESP.
- ACTIVE: s_cyc[owner]=m_cyc. Request to idx==owner: s_stb[owner]=m_stb, m_stall=s_stall[owner] | (outstanding==MAX_OUTSTANDING). Request to a different or unmapped idx: m_stall=1, s_stb=0 until outstanding==0. It is then re-decoded as from IDLE in the same cycle.
- outstanding: +1 on accept, -1 on s_ack[owner]|s_err[owner]; both in one cycle leave it unchanged. Never exceeds MAX_OUTSTANDING and never underflows. Acks with outstanding==0 are ignored.
- Response path is combinational, zero added latency: m_ack=s_ack[owner]&m_cyc, m_err=s_err[owner]&m_cyc, m_data_r=s_data_r[owner]. Acks/errs from non-owner slaves are ignored.
- ACTIVE -> IDLE when outstanding reaches 0 and no accept occurs that cycle, or m_cyc=0.
- ERR_RESP: m_stall=1, m_err=1 for exactly one cycle (next cycle after accept), then IDLE. An unmapped access never asserts any s_cyc.
- Timeout: timer counts clk while outstanding>0 with no ack/err from the owner. It clears on any owner ack/err or accept. At timer==TIMEOUT go ABORT: s_cyc=0, s_stb=0, m_err=1 for one cycle, outstanding<=0, then IDLE. Late acks from the aborted slave are dropped.
- m_cyc deasserted in any state: s_cyc/s_stb drop the same cycle, outstanding<=0, timer<=0, next state IDLE, no m_ack/m_err afterward.
- Master must drop m_cyc after any m_err (Wishbone rule); the block does not enforce this.

Test Plan:
- Reset mid-transfer: 2 outstanding to slave 1, pull rst_n low asynchronously -> s_cyc=0, m_ack=0, outstanding=0 immediately; after release m_stall=0.
- Pipelined read: 4 back-to-back reads to addr 0x0000_0000..0x0000_000C, slave 0 acks each 2 cycles later with 0xA0..0xA3 -> m_ack 4 times in order, m_data_r=0xA0..0xA3, no stall with MAX_OUTSTANDING=4.
- Backpressure: 5th request with 4 outstanding -> m_stall=1 until first ack, then accepted; slave 0 stall=1 propagates to m_stall the same cycle.
- Slave switch: write to slave 0 outstanding, then request to 0x2000_0000 (idx 1) -> stalled until slave-0 ack; s_stb[1] asserted the same cycle outstanding hits 0.
- Unmapped: read 0xE000_0000 (idx 7, NUM_SLAVES=4) -> no s_cyc, m_err=1 exactly one cycle after accept, m_ack=0.
- Timeout: TIMEOUT=8, slave 2 never acks -> m_err pulse 8 cycles after last accept, s_cyc[2]=0; a later s_ack[2] does not produce m_ack.
